// File: rtl/ahb_gpio_irq.sv
// -----------------------------------------------------------------------------
// ahb_gpio_irq
//
// Parametrised AHB-Lite GPIO slave with per-bit direction, pad parity
// generation/checking and an input-edge interrupt controller.
//
// Register map (low ADDR_BITS of HADDR):
//   0x00 DATA  RW    write: DOUT; read: DOUT[i] if DIR[i] else SYNC[i]
//   0x04 DIR   RW    1 = output
//   0x08 IE    RW    per-bit interrupt enable, bit 31 = parity-error enable
//   0x0C IS    R/W1C per-bit edge status, bit 31 = sticky parity-error status
//   0x10 EDGE  RW    per-bit edge select, 0 = rising, 1 = falling
//
// Ports:
//   HCLK       in   bus clock (only clock)
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   [31:0] address (address phase)
//   HTRANS     in   [1:0] transfer type, bit 1 = NONSEQ/SEQ
//   HWRITE     in   1 = write
//   HWDATA     in   [31:0] write data (data phase)
//   HREADY     in   bus ready
//   HREADYOUT  out  always 1, zero wait states
//   HRDATA     out  [31:0] read data, combinational in the data phase
//   GPIOIN     in   [WIDTH:0] input pads, MSB = parity
//   GPIOOUT    out  [WIDTH:0] output pads, MSB = generated parity
//   PARITYSEL  in   0 = even, 1 = odd parity
//   PARITYERR  out  input parity error, valid in the data phase of a DATA read
//   GPIOINT    out  interrupt request, active high
// -----------------------------------------------------------------------------
module ahb_gpio_irq #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    input  logic [WIDTH:0]    GPIOIN,
    output logic [WIDTH:0]    GPIOOUT,
    input  logic              PARITYSEL,
    output logic              PARITYERR,
    output logic              GPIOINT
);

    localparam logic [ADDR_BITS-1:0] ADDR_DATA = ADDR_BITS'(32'h0000_0000);
    localparam logic [ADDR_BITS-1:0] ADDR_DIR  = ADDR_BITS'(32'h0000_0004);
    localparam logic [ADDR_BITS-1:0] ADDR_IE   = ADDR_BITS'(32'h0000_0008);
    localparam logic [ADDR_BITS-1:0] ADDR_IS   = ADDR_BITS'(32'h0000_000C);
    localparam logic [ADDR_BITS-1:0] ADDR_EDGE = ADDR_BITS'(32'h0000_0010);

    // Parity bit that makes XOR(data, bit) equal the selected sense.
    function automatic logic gen_parity(input logic [WIDTH-1:0] data,
                                        input logic             odd_sel);
        return (^data) ^ odd_sel;
    endfunction

    // Flags a pad word (data + parity bit) whose XOR disagrees with the sense.
    function automatic logic chk_parity(input logic [WIDTH:0] word,
                                        input logic           odd_sel);
        return (^word) != odd_sel;
    endfunction

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic                 acc_s;
    logic                 dphase_r;
    logic                 write_r;
    logic [ADDR_BITS-1:0] addr_r;

    logic [WIDTH-1:0]     dout_r;
    logic [WIDTH-1:0]     dir_r;
    logic [WIDTH-1:0]     ie_r;
    logic                 ie31_r;
    logic [WIDTH-1:0]     is_r;
    logic                 is31_r;
    logic [WIDTH-1:0]     edge_sel_r;

    logic [WIDTH:0]       sync1_r;
    logic [WIDTH:0]       sync_r;
    logic [WIDTH-1:0]     prev_r;

    logic                 perr_s;
    logic                 perr_rd_s;
    logic                 parityerr_r;

    logic                 wr_en_s;
    logic                 wr_data_s;
    logic                 wr_dir_s;
    logic                 wr_ie_s;
    logic                 wr_is_s;
    logic                 wr_edge_s;

    logic [WIDTH-1:0]     rise_s;
    logic [WIDTH-1:0]     fall_s;
    logic [WIDTH-1:0]     edge_set_s;
    logic [WIDTH-1:0]     is_clr_s;
    logic                 is31_clr_s;
    logic [WIDTH-1:0]     is_nxt_s;
    logic                 is31_nxt_s;

    logic [WIDTH-1:0]     data_rd_s;
    logic [WIDTH-1:0]     out_data_s;
    logic [31:0]          rdata_s;

    logic                 unused_s;

    // Only the decoded address bits and HTRANS[1] matter to this slave.
    assign unused_s = ^{HADDR, HTRANS, HWDATA};

    // ---------------------------------------------------------------------
    // Bus pipeline
    // ---------------------------------------------------------------------
    assign acc_s = HSEL & HREADY & HTRANS[1];

    // Address-phase capture; the following cycle is the data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_r <= 1'b0;
            write_r  <= 1'b0;
            addr_r   <= {ADDR_BITS{1'b0}};
        end else begin
            dphase_r <= acc_s;
            if (acc_s) begin
                write_r <= HWRITE;
                addr_r  <= HADDR[ADDR_BITS-1:0];
            end
        end
    end

    // Write strobes, active during the data phase of a write.
    always_comb begin
        wr_en_s   = dphase_r & write_r;
        wr_data_s = wr_en_s & (addr_r == ADDR_DATA);
        wr_dir_s  = wr_en_s & (addr_r == ADDR_DIR);
        wr_ie_s   = wr_en_s & (addr_r == ADDR_IE);
        wr_is_s   = wr_en_s & (addr_r == ADDR_IS);
        wr_edge_s = wr_en_s & (addr_r == ADDR_EDGE);
    end

    // Configuration registers; unmapped writes fall through untouched.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dout_r     <= {WIDTH{1'b0}};
            dir_r      <= {WIDTH{1'b0}};
            ie_r       <= {WIDTH{1'b0}};
            ie31_r     <= 1'b0;
            edge_sel_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_data_s) begin
                dout_r <= HWDATA[WIDTH-1:0];
            end
            if (wr_dir_s) begin
                dir_r <= HWDATA[WIDTH-1:0];
            end
            if (wr_ie_s) begin
                ie_r   <= HWDATA[WIDTH-1:0];
                ie31_r <= HWDATA[31];
            end
            if (wr_edge_s) begin
                edge_sel_r <= HWDATA[WIDTH-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Input synchroniser and edge history
    // ---------------------------------------------------------------------
    // Two-flop synchroniser, plus PREV which follows SYNC every cycle so a
    // direction change never looks like an edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_r <= {(WIDTH + 1){1'b0}};
            sync_r  <= {(WIDTH + 1){1'b0}};
            prev_r  <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= GPIOIN;
            sync_r  <= sync1_r;
            prev_r  <= sync_r[WIDTH-1:0];
        end
    end

    assign perr_s = chk_parity(sync_r, PARITYSEL);

    // Edge qualification and W1C masks for the status update.
    always_comb begin
        rise_s     = sync_r[WIDTH-1:0] & ~prev_r;
        fall_s     = ~sync_r[WIDTH-1:0] & prev_r;
        edge_set_s = ((rise_s & ~edge_sel_r) | (fall_s & edge_sel_r)) & ~dir_r;
        if (wr_is_s) begin
            is_clr_s   = HWDATA[WIDTH-1:0];
            is31_clr_s = HWDATA[31];
        end else begin
            is_clr_s   = {WIDTH{1'b0}};
            is31_clr_s = 1'b0;
        end
        // A set in the same cycle as a clear wins.
        is_nxt_s   = edge_set_s | (is_r & ~is_clr_s);
        is31_nxt_s = perr_s | (is31_r & ~is31_clr_s);
    end

    // Interrupt status register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            is_r   <= {WIDTH{1'b0}};
            is31_r <= 1'b0;
        end else begin
            is_r   <= is_nxt_s;
            is31_r <= is31_nxt_s;
        end
    end

    // ---------------------------------------------------------------------
    // Parity error flag for DATA reads
    // ---------------------------------------------------------------------
    assign perr_rd_s = acc_s & ~HWRITE & (HADDR[ADDR_BITS-1:0] == ADDR_DATA);

    // PARITYERR holds PERR for exactly the data phase of a DATA read.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            parityerr_r <= 1'b0;
        end else if (perr_rd_s) begin
            parityerr_r <= perr_s;
        end else begin
            parityerr_r <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    assign data_rd_s = (dout_r & dir_r) | (sync_r[WIDTH-1:0] & ~dir_r);

    // Read data is only driven during a read data phase.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (dphase_r && !write_r) begin
            case (addr_r)
                ADDR_DATA: rdata_s = 32'(data_rd_s);
                ADDR_DIR:  rdata_s = 32'(dir_r);
                ADDR_IE:   rdata_s = {ie31_r, 31'(ie_r)};
                ADDR_IS:   rdata_s = {is31_r, 31'(is_r)};
                ADDR_EDGE: rdata_s = 32'(edge_sel_r);
                default:   rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign out_data_s = dout_r & dir_r;

    // Pads carry DOUT on output bits and zeros on input bits; the top bit
    // balances parity and follows PARITYSEL combinationally.
    always_comb begin
        GPIOOUT = {gen_parity(out_data_s, PARITYSEL), out_data_s};
    end

    assign HREADYOUT = 1'b1;
    assign HRDATA    = rdata_s;
    assign PARITYERR = parityerr_r;
    assign GPIOINT   = (|(is_r & ie_r)) | (is31_r & ie31_r);

endmodule

// File: doc/ahb_gpio_irq.md
Name: ahb_gpio_irq

Overview:
- Parametrised AHB-Lite GPIO slave. Successor to the fixed 16-bit GPIO.
- Generalises the data width and adds per-bit direction, parity generation and checking, and an input-edge interrupt controller (enable mask, edge-polarity select, write-one-to-clear status).
- Sits on the AHB-Lite bus behind the decoder (HSEL). Drives the GPIO pads and one interrupt line to the CPU.

Parameters:
- WIDTH, 16, GPIO data bits (1..31); pad buses are WIDTH+1 bits wide, with MSB = parity bit.
- ADDR_BITS, 8, low HADDR bits decoded for the register map.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  always 1 (zero wait states).
- HRDATA  out  32  read data (data phase).
- GPIOIN  in  WIDTH+1  input pads; bit WIDTH = parity.
- GPIOOUT  out  WIDTH+1  output pads; bit WIDTH = generated parity.
- PARITYSEL  in  1  0 = even parity, 1 = odd parity.
- PARITYERR  out  1  input parity error flag.
- GPIOINT  out  1  interrupt request, active high.

Behaviour:
- Reset (synchronous, HRESET=1 at a posedge HCLK):
  - All registers 0; synchroniser and edge flops 0.
  - GPIOOUT[WIDTH-1:0]=0 and GPIOOUT[WIDTH]=PARITYSEL.
  - HRDATA=0, PARITYERR=0, GPIOINT=0, HREADYOUT=1.
  - A transfer in flight when reset asserts is dropped.
- Address phase:
  - Accept when HSEL && HREADY && HTRANS[1].
  - Latch HADDR[ADDR_BITS-1:0] and HWRITE.
  - Next cycle is the data phase.
- Write: takes effect at the posedge ending the data phase; visible in the following cycle.
- Read: HRDATA is driven combinationally during the data phase from the latched address; zero elsewhere.
- Unused bits read 0. Unmapped addresses read 0, and writes to them are ignored.
- Register map:
  - 0x00 DATA (RW): write sets DOUT[WIDTH-1:0]. Read bit i returns DOUT[i] if DIR[i]=1, else SYNC[i].
  - 0x04 DIR (RW): 1 = output.
  - 0x08 IE (RW): interrupt enable per bit.
  - 0x0C IS (R/W1C): edge status per bit. Bit 31 = sticky parity-error status, also W1C.
  - 0x10 EDGE (RW): per bit, 0 = rising, 1 = falling.
- Pads and parity:
  - GPIOOUT[i] = DOUT[i] when DIR[i]=1, else 0.
  - GPIOOUT[WIDTH] is chosen so that XOR over GPIOOUT[WIDTH:0] == PARITYSEL. It is combinational on PARITYSEL.
- Input path and parity error:
  - GPIOIN passes through a 2-flop synchroniser to SYNC[WIDTH:0].
  - PERR = (XOR over SYNC[WIDTH:0]) != PARITYSEL.
  - PARITYERR is registered: it equals PERR captured at the start of the data phase of a DATA read; otherwise 0.
  - Any cycle with PERR=1 sets IS[31].
- Edges:
  - PREV is SYNC delayed one cycle.
  - rise[i] = SYNC[i] & ~PREV[i]; fall[i] = ~SYNC[i] & PREV[i].
  - An edge on bit i sets IS[i] only when DIR[i]=0 and the edge matches EDGE[i].
  - A GPIOIN change sets IS on the 3rd posedge HCLK after the change.
  - IS bits set regardless of IE.
- GPIOINT = |(IS[WIDTH-1:0] & IE) | (IS[31] & IE[31]). IE[31] is the parity-error interrupt enable. The output is combinational from registers.
- Simultaneous events:
  - A W1C and a new edge on the same bit in the same cycle: set wins, bit stays 1.
  - Writing 0 to an IS bit has no effect.
  - Writing DIR from 1 to 0 does not itself generate an edge, because PREV tracks SYNC continuously.
  - Back-to-back transfers are supported: a new address phase may coincide with the current data phase.
- Idle/BUSY HTRANS, HSEL=0 or HREADY=0 in the address phase: no access.

Test Plan:
- Reset, then write DIR=0xFFFF, DATA=0x1234 with PARITYSEL=0 (WIDTH=16) -> the cycle after the data phase GPIOOUT[15:0]=0x1234 and GPIOOUT[16]=1 (even total). Toggle PARITYSEL=1 -> GPIOOUT[16]=0.
- DIR=0x0000, GPIOIN=0x0ABCD (parity bit 0, XOR=0), PARITYSEL=0, wait 3 cycles, read DATA -> HRDATA=0x0000ABCD, PARITYERR=0. Set GPIOIN=0x1ABCD -> read gives PARITYERR=1 and IS[31]=1.
- DIR=0x00FF, DATA=0xFFFF, GPIOIN[15:8]=0x5A -> DATA read = 0x5AFF, GPIOOUT[15:8]=0x00.
- DIR=0, IE=0x0001, EDGE=0, drive GPIOIN[0] 0->1 -> IS[0]=1 on the 3rd posedge, GPIOINT=1. Write IS=0x1 -> GPIOINT=0 next cycle. Drive GPIOIN[0] 1->0 -> no set.
- EDGE[3]=1, IE[3]=1, a falling edge on bit 3 timed so IS[3] sets in the same cycle a W1C of 0x8 is written -> IS[3] stays 1, GPIOINT stays 1.
- Mid-transfer reset: assert HRESET during the data phase of a DATA write 0xFFFF -> DOUT stays 0, all outputs at reset values the cycle after, HREADYOUT=1.
